// File: rtl/vending_machine_change_if.sv
// vending_machine_change_if: coin/cancel inputs and dispense/change/credit outputs of the vending machine
interface vending_machine_change_if #(parameter int CREDIT_W = 7);
  logic coin_a, coin_b, coin_c, cancel;
  logic dispense, change_out, coin_reject, busy;
  logic [CREDIT_W-1:0] credit;
  modport master(output coin_a, coin_b, coin_c, cancel, input dispense, change_out, coin_reject, busy, credit);
  modport slave(input coin_a, coin_b, coin_c, cancel, output dispense, change_out, coin_reject, busy, credit);
endinterface

// File: rtl/vending_machine_change.sv
// vending_machine_change: three-coin credit accumulator that vends at PRICE and returns excess as unit-coin pulses
module vending_machine_change #(
  parameter int CREDIT_W   = 7,
  parameter int COIN_A     = 5,
  parameter int COIN_B     = 10,
  parameter int COIN_C     = 25,
  parameter int PRICE      = 15,
  parameter int MAX_CREDIT = 95
) (
  input logic clk,
  input logic reset,
  vending_machine_change_if.slave vif
);
  if (COIN_A <= 0 || COIN_B % COIN_A != 0 || COIN_C % COIN_A != 0 || PRICE % COIN_A != 0 ||
      MAX_CREDIT % COIN_A != 0 || PRICE > MAX_CREDIT || MAX_CREDIT >= 2**CREDIT_W ||
      $bits(vif.credit) != CREDIT_W) begin : g_bad_params
    $error("vending_machine_change: illegal parameter set");
  end
  localparam logic [CREDIT_W:0]   VA = (CREDIT_W+1)'(COIN_A);
  localparam logic [CREDIT_W:0]   VB = (CREDIT_W+1)'(COIN_B);
  localparam logic [CREDIT_W:0]   VC = (CREDIT_W+1)'(COIN_C);
  localparam logic [CREDIT_W:0]   VP = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0]   VM = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PA = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UA = CREDIT_W'(COIN_A);
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;
  state_t state, state_nx;
  logic [CREDIT_W-1:0] credit, credit_nx;
  logic [CREDIT_W:0] value, sum;
  logic reject_q, any_coin, accept, taking;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      credit   <= '0;
      reject_q <= 1'b0;
    end else begin
      state    <= state_nx;
      credit   <= credit_nx;
      reject_q <= any_coin && !accept;
    end
  end
  // sum is one bit wider than credit so the MAX_CREDIT check cannot wrap
  always_comb begin
    taking    = state == IDLE || state == COLLECT;
    any_coin  = vif.coin_a | vif.coin_b | vif.coin_c;
    value     = vif.coin_a ? VA : vif.coin_b ? VB : VC;
    sum       = {1'b0, credit} + value;
    accept    = taking && $onehot({vif.coin_a, vif.coin_b, vif.coin_c}) && !vif.cancel && sum <= VM;
    state_nx  = state == VEND ? (credit == PA ? IDLE : CHANGE)
              : state == CHANGE ? (credit <= UA ? IDLE : CHANGE)
              : state == COLLECT && vif.cancel ? CHANGE
              : accept ? (sum >= VP ? VEND : COLLECT)
              : state;
    credit_nx = state == VEND ? credit - PA
              : state == CHANGE ? credit - UA
              : accept ? sum[CREDIT_W-1:0]
              : credit;
  end
  always_comb begin
    vif.dispense    = state == VEND;
    vif.change_out  = state == CHANGE;
    vif.busy        = state == VEND || state == CHANGE;
    vif.coin_reject = reject_q;
    vif.credit      = credit;
  end
endmodule
